// File: rtl/ad9361_pkg.sv
// ad9361_pkg: shared constants and grant-state encoding for the ad9361 sample arbiter.
package ad9361_pkg;

    localparam int NUM_CHAN   = 4;
    localparam int SAMP_WIDTH = 12;

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

endpackage

// File: rtl/samp_fifo.sv
// samp_fifo: single-clock FIFO with first-word-fall-through head.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module samp_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr, rd;

    assign full  = cnt_q == (AW + 1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    assign dout  = mem_q[rd_q];

    always_comb begin
        rd    = pop & ~empty;
        wr    = push & (~full | rd);
        wr_d  = wr ? wr_q + 1'b1 : wr_q;
        rd_d  = rd ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + (AW + 1)'(wr) - (AW + 1)'(rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/ad9361_samp_arb.sv
// ad9361_samp_arb: round-robin burst scheduler sharing one sample port among four
// channel FIFOs, with per-channel saturating drop counters.
module ad9361_samp_arb
    import ad9361_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BURST_MAX  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    chan_en,
    input  logic                          cnt_clr,
    input  logic                          valid_0_in,
    input  logic                          valid_1_in,
    input  logic                          valid_2_in,
    input  logic                          valid_3_in,
    input  logic [11:0]                   data_i0_in,
    input  logic [11:0]                   data_i1_in,
    input  logic [11:0]                   data_i2_in,
    input  logic [11:0]                   data_i3_in,
    input  logic [11:0]                   data_q0_in,
    input  logic [11:0]                   data_q1_in,
    input  logic [11:0]                   data_q2_in,
    input  logic [11:0]                   data_q3_in,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [23:0]                   m_data,
    output logic [1:0]                    m_chan,
    output logic                          m_last,
    output logic [4*CNT_WIDTH-1:0]        drop_cnt,
    output logic                          busy
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int DW = 2 * SAMP_WIDTH;

    state_t                 state_q, state_d;
    logic [1:0]             gnt_q, gnt_d, rr_q, rr_d, cand;
    logic [BW-1:0]          burst_q, burst_d;
    logic [CNT_WIDTH-1:0]   drop_q [NUM_CHAN];
    logic [CNT_WIDTH-1:0]   drop_d [NUM_CHAN];
    logic [NUM_CHAN-1:0]    vld, push_req, pop_v, full_v, empty_v, drop_v;
    logic [DW-1:0]          din_a  [NUM_CHAN];
    logic [DW-1:0]          head_a [NUM_CHAN];
    logic [CW:0]            cnt_a  [NUM_CHAN];
    logic                   found, pop;

    assign vld      = {valid_3_in, valid_2_in, valid_1_in, valid_0_in};
    assign push_req = vld & chan_en;
    assign din_a[0] = {data_i0_in, data_q0_in};
    assign din_a[1] = {data_i1_in, data_q1_in};
    assign din_a[2] = {data_i2_in, data_q2_in};
    assign din_a[3] = {data_i3_in, data_q3_in};
    assign pop      = m_valid & m_ready;
    assign drop_v   = push_req & full_v & ~pop_v;
    assign busy     = ~(&empty_v) | (state_q != IDLE);

    for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
        assign pop_v[k] = pop & (gnt_q == 2'(k));
        assign drop_cnt[(NUM_CHAN-1-k)*CNT_WIDTH +: CNT_WIDTH] = drop_q[k];
        samp_fifo #(
            .WIDTH (DW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_req[k]),
            .pop   (pop_v[k]),
            .din   (din_a[k]),
            .dout  (head_a[k]),
            .full  (full_v[k]),
            .empty (empty_v[k]),
            .count (cnt_a[k])
        );
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        found   = 1'b0;
        cand    = '0;
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = '0;
        m_last  = 1'b0;
        if (state_q == IDLE) begin
            // Scan starts just after the last granted channel so every channel gets a turn.
            for (int i = 1; i <= NUM_CHAN; i++) begin
                cand = rr_q + 2'(i);
                if (!found && !empty_v[cand]) begin
                    found = 1'b1;
                    gnt_d = cand;
                end
            end
            if (found) begin
                rr_d    = gnt_d;
                burst_d = '0;
                state_d = SERVE;
            end
        end else begin
            m_valid = ~empty_v[gnt_q];
            m_data  = m_valid ? head_a[gnt_q] : '0;
            m_chan  = m_valid ? gnt_q : '0;
            m_last  = m_valid & ((burst_q == BW'(BURST_MAX - 1)) |
                      ((cnt_a[gnt_q] == (CW + 1)'(1)) & ~push_req[gnt_q]));
            if (pop) begin
                if (m_last) state_d = IDLE;
                else        burst_d = burst_q + 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CHAN; k++)
            drop_d[k] = cnt_clr ? '0 :
                        (drop_v[k] && !(&drop_q[k])) ? drop_q[k] + 1'b1 : drop_q[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= 2'd3;
            burst_q <= '0;
            for (int k = 0; k < NUM_CHAN; k++) drop_q[k] <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            for (int k = 0; k < NUM_CHAN; k++) drop_q[k] <= drop_d[k];
        end
    end

endmodule

// File: tb/tb_ad9361_samp_arb.sv
// tb_ad9361_samp_arb: directed vector table plus hand sequences for burst cap,
// overflow, backpressure and asynchronous reset.
module tb_ad9361_samp_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  chan_en;
    logic        cnt_clr, m_ready;
    logic [3:0]  vld;
    logic [11:0] di [4];
    logic [11:0] dq [4];

    logic        m_valid, m_last, busy;
    logic [23:0] m_data;
    logic [1:0]  m_chan;
    logic [63:0] drop_cnt;
    logic        b_valid, b_last, b_busy;
    logic [23:0] b_data;
    logic [1:0]  b_chan;
    logic [63:0] b_drop;

    int total = 0;
    int bad   = 0;

    logic [26:0] got [$];
    logic [26:0] ex  [$];

    always #5 clk = ~clk;

    ad9361_samp_arb #(.FIFO_DEPTH(4), .BURST_MAX(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .chan_en(chan_en), .cnt_clr(cnt_clr),
        .valid_0_in(vld[0]), .valid_1_in(vld[1]), .valid_2_in(vld[2]), .valid_3_in(vld[3]),
        .data_i0_in(di[0]), .data_i1_in(di[1]), .data_i2_in(di[2]), .data_i3_in(di[3]),
        .data_q0_in(dq[0]), .data_q1_in(dq[1]), .data_q2_in(dq[2]), .data_q3_in(dq[3]),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
        .m_last(m_last), .drop_cnt(drop_cnt), .busy(busy)
    );

    ad9361_samp_arb #(.FIFO_DEPTH(4), .BURST_MAX(2), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .chan_en(chan_en), .cnt_clr(cnt_clr),
        .valid_0_in(vld[0]), .valid_1_in(vld[1]), .valid_2_in(vld[2]), .valid_3_in(vld[3]),
        .data_i0_in(di[0]), .data_i1_in(di[1]), .data_i2_in(di[2]), .data_i3_in(di[3]),
        .data_q0_in(dq[0]), .data_q1_in(dq[1]), .data_q2_in(dq[2]), .data_q3_in(dq[3]),
        .m_valid(b_valid), .m_ready(m_ready), .m_data(b_data), .m_chan(b_chan),
        .m_last(b_last), .drop_cnt(b_drop), .busy(b_busy)
    );

    typedef struct {
        logic [3:0]  v;
        logic [11:0] i_s, q_s;
        logic        e_v;
        logic [23:0] e_d;
        logic [1:0]  e_c;
        logic        e_l;
        logic        e_b;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic [3:0] v, input logic [11:0] i_s, q_s,
                                input logic e_v, input logic [23:0] e_d,
                                input logic [1:0] e_c, input logic e_l, e_b);
        vec_t r;
        r.v = v; r.i_s = i_s; r.q_s = q_s; r.e_v = e_v;
        r.e_d = e_d; r.e_c = e_c; r.e_l = e_l; r.e_b = e_b;
        return r;
    endfunction

    function automatic logic [26:0] beat(input logic [1:0] c, input logic l, input logic [23:0] d);
        return {c, l, d};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        vld = '0;
        cnt_clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            di[k] = '0;
            dq[k] = '0;
        end
    endtask

    task automatic pulse_rst;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic collect(input int cycles, input int stop_at, input bit use_b);
        got.delete();
        for (int c = 0; c < cycles && got.size() < stop_at; c++) begin
            #2;
            if (use_b ? (b_valid && m_ready) : (m_valid && m_ready))
                got.push_back(use_b ? beat(b_chan, b_last, b_data) : beat(m_chan, m_last, m_data));
            tick();
        end
    endtask

    task automatic cmp_beats(input string nm);
        chk({nm, "_count"}, 64'(got.size()), 64'(ex.size()));
        for (int i = 0; i < ex.size(); i++)
            if (i < got.size()) chk($sformatf("%s_beat%0d", nm, i), 64'(got[i]), 64'(ex[i]));
    endtask

    initial begin
        logic [15:0] pat;
        logic        stall;
        logic [26:0] held;
        int          n;

        rst = 1'b1;
        chan_en = 4'hF;
        m_ready = 1'b1;
        clr_in();
        #2;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_chan", m_chan, 0);
        chk("rst_last", m_last, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Fairness: every channel queues three samples, grants rotate 0,1,2,3.
        tbl[0] = mk(4'hF, 12'h001, 12'h101, 0, 24'h0, 0, 0, 0);
        tbl[1] = mk(4'hF, 12'h002, 12'h102, 0, 24'h0, 0, 0, 1);
        tbl[2] = mk(4'hF, 12'h003, 12'h103, 1, 24'h001101, 0, 0, 1);
        tbl[3] = mk(4'h0, 12'h000, 12'h000, 1, 24'h002102, 0, 0, 1);
        tbl[4] = mk(4'h0, 12'h000, 12'h000, 1, 24'h003103, 0, 1, 1);
        for (int c = 1; c < 4; c++) begin
            tbl[1 + 4*c] = mk(4'h0, 0, 0, 0, 24'h0, 0, 0, 1);
            for (int j = 0; j < 3; j++)
                tbl[2 + 4*c + j] = mk(4'h0, 0, 0, 1, {12'h001 + 12'(j), 12'h101 + 12'(j)},
                                      2'(c), j == 2, 1);
        end
        tbl[17] = mk(4'h0, 12'h000, 12'h000, 0, 24'h0, 0, 0, 0);
        tbl[18] = mk(4'h4, 12'h123, 12'hABC, 0, 24'h0, 0, 0, 0);
        tbl[19] = mk(4'h0, 12'h000, 12'h000, 0, 24'h0, 0, 0, 1);
        tbl[20] = mk(4'h0, 12'h000, 12'h000, 1, 24'h123ABC, 2, 1, 1);
        tbl[21] = mk(4'h0, 12'h000, 12'h000, 0, 24'h0, 0, 0, 0);

        for (int r = 0; r < 22; r++) begin
            vld = tbl[r].v;
            for (int k = 0; k < 4; k++) begin
                di[k] = tbl[r].i_s;
                dq[k] = tbl[r].q_s;
            end
            #2;
            chk($sformatf("tbl%0d_valid", r), m_valid, tbl[r].e_v);
            if (tbl[r].e_v) begin
                chk($sformatf("tbl%0d_data", r), m_data, tbl[r].e_d);
                chk($sformatf("tbl%0d_chan", r), m_chan, tbl[r].e_c);
                chk($sformatf("tbl%0d_last", r), m_last, tbl[r].e_l);
            end
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_b);
            tick();
        end
        clr_in();

        // Burst cap of 2 on the second instance.
        pulse_rst();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vld = (i == 0) ? 4'b0011 : 4'b0001;
            di[0] = 12'h010 + 12'(i);
            dq[0] = 12'h020 + 12'(i);
            di[1] = 12'h7FF;
            dq[1] = 12'h055;
            tick();
        end
        clr_in();
        m_ready = 1'b1;
        collect(30, 5, 1'b1);
        ex.delete();
        ex.push_back(beat(0, 0, 24'h010020));
        ex.push_back(beat(0, 1, 24'h011021));
        ex.push_back(beat(1, 1, 24'h7FF055));
        ex.push_back(beat(0, 0, 24'h012022));
        ex.push_back(beat(0, 1, 24'h013023));
        cmp_beats("burst");

        // Overflow on channel 3 while channel 2 is disabled but strobing.
        pulse_rst();
        m_ready = 1'b0;
        chan_en = 4'b1011;
        for (int i = 0; i < 10; i++) begin
            vld = 4'b1100;
            di[3] = 12'h300 + 12'(i);
            dq[3] = 12'h0C0 + 12'(i);
            di[2] = 12'h222;
            dq[2] = 12'h222;
            tick();
        end
        vld = '0;
        #2;
        chk("ovf_drop", drop_cnt, 64'd6);
        chk("ovf_valid", m_valid, 1);
        chk("ovf_head", m_data, 24'h3000C0);
        tick();
        cnt_clr = 1'b1;
        vld = 4'b1000;
        tick();
        clr_in();
        #2;
        chk("ovf_clr", drop_cnt, 0);
        chan_en = 4'hF;
        m_ready = 1'b1;
        collect(15, 99, 1'b0);
        ex.delete();
        for (int i = 0; i < 4; i++)
            ex.push_back(beat(3, i == 3, {12'h300 + 12'(i), 12'h0C0 + 12'(i)}));
        cmp_beats("ovf_drain");

        // Backpressure across two grants.
        pulse_rst();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld = 4'b0110;
            di[1] = 12'h410 + 12'(i);
            dq[1] = 12'h510 + 12'(i);
            di[2] = 12'h620 + 12'(i);
            dq[2] = 12'h720 + 12'(i);
            tick();
        end
        clr_in();
        pat = 16'b1011001011010110;
        stall = 1'b0;
        held = '0;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            m_ready = pat[c % 16];
            #2;
            if (stall) begin
                chk("bp_hold_valid", m_valid, 1);
                chk("bp_hold_beat", beat(m_chan, m_last, m_data), held);
            end
            if (m_valid && m_ready) got.push_back(beat(m_chan, m_last, m_data));
            stall = m_valid & ~m_ready;
            held = beat(m_chan, m_last, m_data);
            tick();
        end
        ex.delete();
        for (int i = 0; i < 3; i++)
            ex.push_back(beat(1, i == 2, {12'h410 + 12'(i), 12'h510 + 12'(i)}));
        for (int i = 0; i < 3; i++)
            ex.push_back(beat(2, i == 2, {12'h620 + 12'(i), 12'h720 + 12'(i)}));
        cmp_beats("bp");

        // Asynchronous reset in the middle of serving channel 2.
        pulse_rst();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vld = 4'b0100;
            di[2] = 12'h0A0 + 12'(i);
            dq[2] = 12'h0B0;
            tick();
        end
        clr_in();
        #2;
        chk("ar_pre_valid", m_valid, 1);
        chk("ar_pre_chan", m_chan, 2);
        chk("ar_pre_drop", drop_cnt, 64'h0000_0000_0001_0000);
        #1 rst = 1'b1;
        #1;
        chk("ar_valid", m_valid, 0);
        chk("ar_data", m_data, 0);
        chk("ar_last", m_last, 0);
        chk("ar_busy", busy, 0);
        chk("ar_drop", drop_cnt, 0);
        rst = 1'b0;
        tick();
        vld = 4'b1001;
        di[0] = 12'h0D0;
        dq[0] = 12'h0D1;
        di[3] = 12'h0E0;
        dq[3] = 12'h0E1;
        m_ready = 1'b1;
        tick();
        clr_in();
        collect(10, 99, 1'b0);
        ex.delete();
        ex.push_back(beat(0, 1, 24'h0D00D1));
        ex.push_back(beat(3, 1, 24'h0E00E1));
        cmp_beats("ar_post");

        n = total;
        $display("test done: total=%0d bad=%0d", n, bad);
        $finish;
    end

endmodule

// File: doc/ad9361_samp_arb.md
Name: ad9361_samp_arb

Overview:
- Four-channel round-robin scheduler that shares one downstream sample port (FIFO/DMA writer) between the four gated channel streams produced by the ad9361 sample filter.
- Each channel has a small holding FIFO. A grant state machine serves one channel at a time in bursts and tags every beat with its channel number.
- Per-channel saturating drop counters report overflow to software.

Parameters:
- FIFO_DEPTH, 4, entries per channel FIFO; power of 2, >= 2.
- BURST_MAX, 8, maximum beats served per grant before rotating; >= 1.
- CNT_WIDTH, 16, width of each drop counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- chan_en  in  4  per-channel enable; bit k = channel k
- cnt_clr  in  1  synchronous clear of all drop counters
- valid_0_in .. valid_3_in  in  1 each  channel sample strobe
- data_i0_in .. data_i3_in  in  12 each  channel I sample
- data_q0_in .. data_q3_in  in  12 each  channel Q sample
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  24  {I[11:0], Q[11:0]} of the current beat
- m_chan  out  2  channel of the current beat
- m_last  out  1  final beat of the current grant
- drop_cnt  out  4*CNT_WIDTH  drop counters; channel 0 in the MSBs, channel 3 in the LSBs
- busy  out  1  any FIFO non-empty or state != IDLE

Behaviour:
- Reset (async, rst=1):
  - FIFOs empty, state IDLE, rr_ptr=3 (channel 0 has first priority), burst counter 0, drop counters 0.
  - All outputs 0.
  - Reset mid-burst discards all queued samples; no partial beat is presented.
- Push:
  - Condition: valid_k_in & chan_en[k], written at the clock edge.
  - Accepted if FIFO k is not full, or if it is full and a pop of channel k occurs in the same cycle.
  - Otherwise the sample is dropped and drop_cnt[k] increments, saturating at all-ones.
  - Disabled channels neither push nor count.
- cnt_clr=1 clears all counters. A drop in the same cycle is lost; the counter reads 0 afterwards.
- Pop: m_valid & m_ready. The head advances and the count decrements. Simultaneous push and pop keeps the count.
- State machine:
  - IDLE:
    - Search channels rr_ptr+1, rr_ptr+2, ... (mod 4) for the first non-empty FIFO.
    - If found, set gnt=that channel, rr_ptr=gnt, burst=0, and go to SERVE. Otherwise stay in IDLE.
    - m_valid=0 in IDLE.
  - SERVE:
    - m_valid = FIFO[gnt] non-empty. m_data = FIFO[gnt] head. m_chan = gnt.
    - m_last = (burst==BURST_MAX-1) or (count[gnt]==1 with no same-cycle push to gnt).
    - On pop with m_last=1, go to IDLE. On pop otherwise, burst+1.
    - If chan_en[gnt] drops while SERVE, queued samples for gnt are still drained.
    - m_data/m_chan/m_last are held stable while m_valid & !m_ready.
- Latency and throughput:
  - A sample pushed at edge t into an idle block appears on m_valid in the cycle after edge t+1, i.e. 2 cycles.
  - One bubble cycle (IDLE) occurs between grants.
  - Sustained throughput is <= 1 beat/clk. The aggregate input rate above that overflows into the drop counters by design.
- All arithmetic is unsigned. FIFO pointers wrap modulo FIFO_DEPTH; occupancy uses log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package ad9361_pkg: NUM_CHAN=4, SAMP_WIDTH=12, state encoding {IDLE, SERVE}.
- Sub-module samp_fifo: single-clock FIFO, WIDTH=24, DEPTH=FIFO_DEPTH.
  - Ports: push/pop, full/empty/count, first-word-fall-through head.
  - Instantiated 4 times in a generate loop.
- Arbiter, FSM and counters live in the top.

Test Plan:
- Single sample: ch2 sample I=0x123, Q=0xABC, m_ready=1.
  -> m_valid 2 cycles later with m_data=0x123ABC, m_chan=2, m_last=1; busy falls the next cycle.
- Fairness: all 4 channels each push 3 samples in one cycle, m_ready=1, BURST_MAX=8.
  -> grants in order 0,1,2,3; 3 beats each; m_last on the 3rd beat; one idle cycle between grants.
- Burst cap: BURST_MAX=2; ch0 holds 4 samples and ch1 holds 1.
  -> order ch0,ch0(last),ch1(last),ch0,ch0(last).
- Overflow: FIFO_DEPTH=4, m_ready=0; ch3 pushes 10 consecutive samples.
  -> 4 queued, drop_cnt[3]=6.
  -> Then cnt_clr=1 -> drop_cnt[3]=0.
  -> Then m_ready=1 drains the first 4 samples in order.
- Backpressure: toggle m_ready pseudo-randomly during a 6-beat stream.
  -> m_data/m_chan/m_last stable while m_valid & !m_ready; no beat lost or duplicated.
- Async reset mid-SERVE (rst pulsed between clock edges).
  -> m_valid=0 immediately; FIFOs empty, counters 0; next grant starts at channel 0.
